board_burst_forwarder: RTL and testbench

- Control and datapath stage wrapped around the 8-board round-robin arbiter.
- Presents per-board request status to the arbiter and pulses its enable.
- Consumes the registered 4-bit board select and forwards one fixed-length burst from the granted board channel to a single downstream valid/ready stream.
- Sits between the eight board ingress FIFOs and the shared egress link.

---
 rtl/board_burst_forwarder.sv | 106 ++++++++++
 tb/tb_board_burst_forwarder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_burst_forwarder.sv
// board_burst_forwarder: requests arbitration for the eight board channels and forwards one
// fixed-length burst from the granted board to a single valid/ready egress stream.
//   clk, rst_n      clock, synchronous active-low reset
//   board_valid     per-board word available (ingress FIFO non-empty)
//   board_data      board b word at [b*DATA_W +: DATA_W]
//   board_ready     per-board pop strobe (only the selected board, only in XFER)
//   req_mask        request vector to the arbiter (mirrors board_valid)
//   arb_enable      one-cycle arbitration pulse
//   board_sel       arbiter grant index, 0-7 valid, 8 or above means no grant
//   out_valid/out_data/out_board_id/out_last/out_ready   egress stream
//   busy            high whenever the FSM is not in IDLE
//   timeout_err     sticky, set when a burst is aborted for a stalled source
//   burst_cnt       completed bursts, wrapping
module board_burst_forwarder #(
    parameter int DATA_W        = 64,
    parameter int BURST_LEN     = 16,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            board_valid,
    input  logic [8*DATA_W-1:0]   board_data,
    output logic [7:0]            board_ready,
    output logic [7:0]            req_mask,
    output logic                  arb_enable,
    input  logic [3:0]            board_sel,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_board_id,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           burst_cnt
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ARB, WAIT, SAMPLE, XFER} state_t;
    state_t          r_state;
    logic [2:0]      r_sel;
    logic [BW-1:0]   r_beat;
    logic [SW-1:0]   r_stall;
    logic            r_timeout_err;
    logic [15:0]     r_burst_cnt;
    logic            w_xfer;
    logic            w_sel_valid;
    logic            w_hs;
    assign w_xfer       = r_state == XFER;
    assign w_sel_valid  = board_valid[r_sel];
    assign w_hs         = out_valid & out_ready;
    assign req_mask     = board_valid;
    assign arb_enable   = r_state == ARB;
    assign busy         = r_state != IDLE;
    assign out_valid    = w_xfer & w_sel_valid;
    assign out_data     = w_xfer ? board_data[int'(r_sel)*DATA_W +: DATA_W] : '0;
    assign out_board_id = r_sel;
    assign out_last     = out_valid & (r_beat == BW'(BURST_LEN - 1));
    assign board_ready  = w_xfer ? (8'(out_ready) << r_sel) : 8'h00;
    assign timeout_err  = r_timeout_err;
    assign burst_cnt    = r_burst_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sel         <= '0;
            r_beat        <= '0;
            r_stall       <= '0;
            r_timeout_err <= 1'b0;
            r_burst_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE:   r_state <= |board_valid ? ARB : IDLE;
                ARB:    r_state <= WAIT;
                WAIT:   r_state <= SAMPLE;
                SAMPLE: begin
                    // board_sel of 8 or more is an empty grant; retry from IDLE
                    if (!board_sel[3]) begin
                        r_sel   <= board_sel[2:0];
                        r_beat  <= '0;
                        r_stall <= '0;
                        r_state <= XFER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                XFER: begin
                    if (w_hs) begin
                        r_stall <= '0;
                        r_beat  <= r_beat + 1'b1;
                        if (out_last) begin
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                            r_state     <= IDLE;
                        end
                    end else if (!w_sel_valid) begin
                        // only a starved source counts; downstream backpressure holds the count
                        r_stall <= (r_stall == SW'(STALL_TIMEOUT)) ? r_stall : r_stall + 1'b1;
                        if (r_stall >= SW'(STALL_TIMEOUT - 1)) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_burst_forwarder.sv
// tb_board_burst_forwarder: scoreboard bench with board FIFO models and a round-robin arbiter model.
module tb_board_burst_forwarder;
    localparam int W  = 64;
    localparam int BL = 16;
    localparam int TO = 255;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        board_valid;
    logic [8*W-1:0]    board_data;
    logic [7:0]        board_ready;
    logic [7:0]        req_mask;
    logic              arb_enable;
    logic [3:0]        board_sel;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [2:0]        out_board_id;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       burst_cnt;
    always #5 clk = ~clk;
    board_burst_forwarder #(.DATA_W(W), .BURST_LEN(BL), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .board_valid(board_valid), .board_data(board_data),
        .board_ready(board_ready), .req_mask(req_mask), .arb_enable(arb_enable),
        .board_sel(board_sel), .out_valid(out_valid), .out_data(out_data),
        .out_board_id(out_board_id), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err), .burst_cnt(burst_cnt)
    );
    // Arbiter model: two-register latency, round-robin after the last grant, and the last
    // granted board is skipped once so a lone requester sees grant, empty grant, grant.
    logic [3:0] a_stage;
    logic [2:0] a_last;
    logic       a_excl;
    logic [3:0] w_pick;
    function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] last, input logic excl);
        logic [2:0] b;
        for (int i = 1; i <= 8; i++) begin
            b = last + 3'(i);
            if (req[b] && !(excl && b == last)) return {1'b0, b};
        end
        return 4'd8;
    endfunction
    assign w_pick = pick(req_mask, a_last, a_excl);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_stage   <= 4'd8;
            board_sel <= 4'd8;
            a_last    <= 3'd7;
            a_excl    <= 1'b0;
        end else begin
            board_sel <= a_stage;
            if (arb_enable) begin
                a_stage <= w_pick;
                a_excl  <= !w_pick[3];
                if (!w_pick[3]) a_last <= w_pick[2:0];
            end
        end
    end
    logic [W-1:0] fq [8][$];
    logic [W-1:0] eq [8][$];
    logic [7:0]   pend;
    int           burst_ids [$];
    int cyc, n_vec, n_err, tb_beat, hs_cnt, bursts_seen, arb_cnt, first_hs_cyc, last_hs_cyc;
    logic bp_mode;
    task automatic refresh();
        for (int b = 0; b < 8; b++) begin
            board_valid[b] = fq[b].size() != 0;
            board_data[b*W +: W] = board_valid[b] ? fq[b][0] : '0;
        end
    endtask
    task automatic load(input int b, input int n);
        logic [W-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = {8'(b), 24'(k), $urandom()};
            fq[b].push_back(d);
            eq[b].push_back(d);
        end
        refresh();
    endtask
    task automatic monitor();
        logic [7:0]   stray;
        logic         exp_last;
        logic [W-1:0] e;
        stray = board_ready & ~(8'b1 << out_board_id);
        n_vec++;
        if (stray !== 8'h00) begin
            n_err++;
            $display("FAIL stray_ready: board_ready=%b with out_board_id=%0d, required no other bit", board_ready, out_board_id);
        end
        exp_last = out_valid === 1'b1 && tb_beat == BL - 1;
        n_vec++;
        if (out_last !== exp_last) begin
            n_err++;
            $display("FAIL out_last: got %b required %b at beat %0d", out_last, exp_last, tb_beat);
        end
        if (arb_enable === 1'b1) arb_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            pend[out_board_id] = 1'b1;
            hs_cnt++;
            if (tb_beat == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            n_vec++;
            if (eq[out_board_id].size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: board %0d data %h, required none", out_board_id, out_data);
            end else begin
                e = eq[out_board_id].pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL data: board %0d got %h required %h", out_board_id, out_data, e);
                end
            end
            if (out_last === 1'b1) begin
                bursts_seen++;
                burst_ids.push_back(int'(out_board_id));
                tb_beat = 0;
            end else begin
                tb_beat++;
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        for (int b = 0; b < 8; b++) if (pend[b] && fq[b].size() != 0) void'(fq[b].pop_front());
        pend = '0;
        if (bp_mode) out_ready = ~out_ready;
        refresh();
        @(negedge clk);
        cyc++;
        monitor();
    endtask
    task automatic wait_bursts(input int target, input int limit);
        for (int i = 0; i < limit && bursts_seen < target; i++) tick();
        n_vec++;
        if (bursts_seen < target) begin
            n_err++;
            $display("FAIL burst_wait: saw %0d bursts, required %0d", bursts_seen, target);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec += 7;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (arb_enable !== 1'b0) begin n_err++; $display("FAIL rst_arb: got %b required 0", arb_enable); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        if (board_ready !== 8'h00) begin n_err++; $display("FAIL rst_ready: got %b required 0", board_ready); end
        if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL rst_bcnt: got %0d required 0", burst_cnt); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_terr: got %b required 0", timeout_err); end
        if (out_board_id !== 3'd0) begin n_err++; $display("FAIL rst_id: got %0d required 0", out_board_id); end
        rst_n = 1'b1;
    endtask
    task automatic test_single();
        int ta, t0;
        ta = -1;
        t0 = bursts_seen;
        load(3, BL);
        for (int i = 0; i < 20 && ta < 0; i++) begin
            tick();
            if (arb_enable === 1'b1) ta = cyc;
        end
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
        n_vec += 2;
        if (out_valid !== 1'b1 || ta < 0 || cyc - ta != 3) begin
            n_err++;
            $display("FAIL first_latency: first word %0d cycles after arb pulse (valid=%b), required 3", cyc - ta, out_valid);
        end
        if (out_board_id !== 3'd3) begin n_err++; $display("FAIL single_id: got %0d required 3", out_board_id); end
        wait_bursts(t0 + 1, 100);
        n_vec++;
        if (last_hs_cyc - first_hs_cyc != BL - 1) begin
            n_err++;
            $display("FAIL single_span: words over %0d cycles, required %0d", last_hs_cyc - first_hs_cyc + 1, BL);
        end
        tick();
        n_vec += 2;
        if (burst_cnt !== 16'd1) begin n_err++; $display("FAIL single_bcnt: got %0d required 1", burst_cnt); end
        if (eq[3].size() != 0) begin n_err++; $display("FAIL single_left: %0d words not forwarded, required 0", eq[3].size()); end
    endtask
    task automatic test_alternate();
        int t0;
        t0 = bursts_seen;
        load(1, 2*BL);
        load(5, 2*BL);
        wait_bursts(t0 + 4, 600);
        if (burst_ids.size() >= t0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (burst_ids[t0+i] != 1 && burst_ids[t0+i] != 5) begin
                    n_err++;
                    $display("FAIL alt_src: burst %0d from board %0d, required 1 or 5", i, burst_ids[t0+i]);
                end
                if (i > 0) begin
                    n_vec++;
                    if (burst_ids[t0+i] == burst_ids[t0+i-1]) begin
                        n_err++;
                        $display("FAIL alt_order: burst %0d board %0d repeats, required alternation", i, burst_ids[t0+i]);
                    end
                end
            end
        end
        tick();
        n_vec += 2;
        if (eq[1].size() + eq[5].size() != 0) begin n_err++; $display("FAIL alt_left: %0d words left, required 0", eq[1].size() + eq[5].size()); end
        if (burst_cnt !== 16'd5) begin n_err++; $display("FAIL alt_bcnt: got %0d required 5", burst_cnt); end
    endtask
    task automatic test_backpressure();
        int t0;
        t0 = bursts_seen;
        load(0, BL);
        bp_mode = 1'b1;
        wait_bursts(t0 + 1, 200);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec += 4;
        if (last_hs_cyc - first_hs_cyc + 1 != 2*BL - 1) begin
            n_err++;
            $display("FAIL bp_span: %0d words over %0d cycles, required %0d cycles", BL, last_hs_cyc - first_hs_cyc + 1, 2*BL - 1);
        end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL bp_terr: got %b required 0", timeout_err); end
        if (eq[0].size() != 0) begin n_err++; $display("FAIL bp_left: %0d words left, required 0", eq[0].size()); end
        if (burst_cnt !== 16'd6) begin n_err++; $display("FAIL bp_bcnt: got %0d required 6", burst_cnt); end
    endtask
    task automatic test_empty_grant();
        int t0, a0;
        t0 = bursts_seen;
        a0 = arb_cnt;
        load(6, 2*BL);
        wait_bursts(t0 + 2, 300);
        repeat (6) tick();
        n_vec += 3;
        if (arb_cnt - a0 != 3) begin n_err++; $display("FAIL eg_rounds: %0d arb pulses, required 3", arb_cnt - a0); end
        if (burst_ids.size() < t0 + 2 || burst_ids[t0] != 6 || burst_ids[t0+1] != 6) begin
            n_err++;
            $display("FAIL eg_src: bursts not both from board 6");
        end
        if (burst_cnt !== 16'd8) begin n_err++; $display("FAIL eg_bcnt: got %0d required 8", burst_cnt); end
    endtask
    task automatic test_timeout();
        int t0, h0, n;
        t0 = bursts_seen;
        h0 = hs_cnt;
        n = 0;
        load(2, 5);
        for (int i = 0; i < 50 && hs_cnt - h0 < 5; i++) tick();
        n_vec++;
        if (hs_cnt - h0 != 5) begin n_err++; $display("FAIL to_words: %0d words, required 5", hs_cnt - h0); end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (busy !== 1'b1) break;
            n++;
        end
        tb_beat = 0;
        n_vec += 4;
        if (n != TO) begin n_err++; $display("FAIL to_cycles: abort after %0d stalled cycles, required %0d", n, TO); end
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_terr: got %b required 1", timeout_err); end
        if (bursts_seen != t0) begin n_err++; $display("FAIL to_last: %0d bursts completed, required 0", bursts_seen - t0); end
        if (burst_cnt !== 16'd8) begin n_err++; $display("FAIL to_bcnt: got %0d required 8", burst_cnt); end
    endtask
    task automatic test_reset_mid();
        int h0, t0;
        h0 = hs_cnt;
        load(4, BL);
        for (int i = 0; i < 60 && hs_cnt - h0 < 7; i++) tick();
        n_vec++;
        if (hs_cnt - h0 != 7) begin n_err++; $display("FAIL rm_reach: %0d words before reset, required 7", hs_cnt - h0); end
        rst_n = 1'b0;
        tick();
        n_vec += 5;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b required 0", busy); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b required 0", out_valid); end
        if (board_ready !== 8'h00) begin n_err++; $display("FAIL rm_ready: got %b required 0", board_ready); end
        if (burst_cnt !== 16'd0) begin n_err++; $display("FAIL rm_bcnt: got %0d required 0", burst_cnt); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rm_terr: got %b required 0", timeout_err); end
        fq[4].delete();
        eq[4].delete();
        tb_beat = 0;
        refresh();
        tick();
        rst_n = 1'b1;
        t0 = bursts_seen;
        load(4, BL);
        wait_bursts(t0 + 1, 100);
        tick();
        n_vec += 3;
        if (burst_cnt !== 16'd1) begin n_err++; $display("FAIL rm_bcnt2: got %0d required 1", burst_cnt); end
        if (eq[4].size() != 0) begin n_err++; $display("FAIL rm_left: %0d words left, required 0", eq[4].size()); end
        if (burst_ids.size() == 0 || burst_ids[burst_ids.size()-1] != 4) begin n_err++; $display("FAIL rm_src: last burst not from board 4"); end
    endtask
    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        bp_mode = 1'b0;
        pend = '0;
        refresh();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_empty_grant();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
